ahb_dmem_slave: RTL and testbench
=================================

// Module: ahb_dmem_slave
// PURPOSE
// - AHB-Lite data-memory responder on the MEM-stage data bus; the slave end of the bus the pipeline drives during load/store.
// - Decodes the address phase, inserts WAIT_STATES wait cycles, then commits stores or returns load data.
// - Flags misaligned, oversized and out-of-range accesses with the two-cycle AHB ERROR response.
// - Holds a synchronous-write, asynchronous-read word array of MEM_DEPTH words.
// PARAMETERS
// - MEM_DEPTH    1024  words of storage; word index = HADDR[ADDR_LSB+:log2(MEM_DEPTH)]
// - WAIT_STATES  0     HREADYOUT-low cycles per OKAY transfer (0..15)
// - BASE_ADDR    32'h0 byte address of word 0; accesses outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH) error
// PORTS
// - clk        in   1   clock, rising edge
// - rst_n      in   1   reset, asynchronous, active-low
// - HSEL       in   1   slave select from decoder
// - HADDR      in   32  byte address (address phase)
// - HTRANS     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// - HWRITE     in   1   1 = store, 0 = load
// - HSIZE      in   3   000 byte, 001 half, 010 word; others illegal
// - HWDATA     in   32  store data (data phase)
// - HREADY     in   1   bus-wide ready; address phase sampled only when 1
// - HREADYOUT  out  1   this slave's ready
// - HRESP      out  1   0 OKAY, 1 ERROR
// - HRDATA     out  32  load data, valid when HREADYOUT=1 at end of a read data phase
// BEHAVIOUR
// - Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0, latched phase regs 0. Memory contents not reset.
// - Reset asserted mid-transfer aborts it: no write commits and outputs return to reset values immediately.
// - Accept: HSEL && HREADY && HTRANS[1] at a rising edge latches HADDR, HWRITE and HSIZE.
//   - IDLE/BUSY or !HSEL: the next data phase is OKAY with zero waits.
// - Illegal if any of:
//   - HSIZE > 010;
//   - half access with HADDR[0]=1;
//   - word access with HADDR[1:0]!=0;
//   - address out of range.
// - FSM: IDLE, WAIT, DATA, ERR1, ERR2.
//   - IDLE: on a legal accept go to WAIT if WAIT_STATES>0, else DATA; on an illegal accept go to ERR1.
//   - WAIT: HREADYOUT=0, HRESP=0; count down from WAIT_STATES-1; at 0 go to DATA.
//   - DATA: HREADYOUT=1, HRESP=0; the transfer completes this cycle. A new accept in the same cycle chains back-to-back with no idle cycle.
//   - ERR1: HREADYOUT=0, HRESP=1; always go to ERR2.
//   - ERR2: HREADYOUT=1, HRESP=1. A new accept here is handled as from IDLE. No memory write occurs for an errored transfer.
// - Store commits at the rising edge ending DATA.
//   - Byte lanes come from the latched HSIZE and HADDR[1:0] (little-endian); lanes not addressed are unchanged.
//   - Byte: lane = addr[1:0]. Half: lanes {addr[1],0} and {addr[1],1}. Word: all four lanes.
// - Load: in DATA, HRDATA = full 32-bit word at the latched index, lanes unshifted; the master extracts bytes.
//   - HRDATA=0 in every other state and on write transfers.
// - Read-after-write: a load whose data phase follows a store's DATA cycle returns the newly written bytes (no bypass needed).
// - Latency: an OKAY transfer spans 1+WAIT_STATES data-phase cycles; an ERROR transfer spans exactly 2.
// - HWDATA is sampled only at the commit edge; HWDATA during WAIT cycles is ignored.
// TESTING
// - Word store 0xDEADBEEF @0x10, then load @0x10, WAIT_STATES=0 -> HREADYOUT=1 each data phase, HRDATA=0xDEADBEEF, HRESP=0.
// - Byte store 0xAA @0x13 over word 0x11223344 -> load @0x10 returns 0xAA223344; half store 0x5566 @0x12 -> 0x55663344.
// - WAIT_STATES=3, load -> HREADYOUT low exactly 3 cycles, high on the 4th with data; HWDATA toggling during waits has no effect on stores.
// - Word load @0x02, HSIZE=011 @0x0, and @BASE_ADDR+4*MEM_DEPTH -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1); memory unchanged.
// - Back-to-back: NONSEQ store @0x20 then NONSEQ load @0x20 in consecutive cycles -> load returns the stored word with no extra wait; interleave BUSY/IDLE -> OKAY, zero waits.
// - rst_n pulled low during WAIT of a store -> HREADYOUT=1, HRESP=0, HRDATA=0 at once; target word keeps its old value.

Source files
------------

// File: rtl/ahb_dmem_slave_if.sv
// rtl/ahb_dmem_slave_if.sv - AHB-Lite data-memory bus bundle with master/slave views
interface ahb_dmem_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_dmem_slave.sv
// rtl/ahb_dmem_slave.sv - AHB-Lite data-memory slave with wait states and two-cycle error response
module ahb_dmem_slave #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  ahb_dmem_slave_if.slave bus
);

  localparam int unsigned ADDR_LSB  = 2;
  localparam int unsigned AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] SPAN      = 33'(MEM_DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [AW+ADDR_LSB-1:0] addr_q, addr_d;
  logic                   write_q, write_d;
  logic [2:0]             size_q, size_d;

  // Synchronous-write, asynchronous-read storage; contents survive reset.
  logic [31:0] mem [MEM_DEPTH];

  logic [32:0]   offset;
  logic          in_range;
  logic          misaligned;
  logic          illegal;
  logic          can_accept;
  logic          accept;
  logic [AW-1:0] idx_q;
  logic [3:0]    lane_en;
  logic          commit;
  logic          hreadyout;
  logic          hresp;
  logic [31:0]   hrdata;
  logic          unused_htrans;

  // HTRANS[0] only separates BUSY from IDLE and NONSEQ from SEQ; neither matters here.
  assign unused_htrans = bus.HTRANS[0];

  // Borrow out of the 33-bit subtraction means the address sits below the window.
  assign offset   = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
  assign in_range = !offset[32] && (offset < SPAN);

  assign misaligned = ((bus.HSIZE == 3'b001) && bus.HADDR[0]) ||
                      ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
  assign illegal    = (bus.HSIZE > 3'b010) || misaligned || !in_range;

  // Address phases can only complete while this slave is driving HREADYOUT high.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign accept     = can_accept && bus.HSEL && bus.HREADY && bus.HTRANS[1];

  assign idx_q  = addr_q[ADDR_LSB +: AW];
  assign commit = (state_q == ST_DATA) && write_q;

  // Little-endian byte lanes touched by the latched transfer.
  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      3'b000:  lane_en[addr_q[1:0]] = 1'b1;
      3'b001:  lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // Next-state, address-phase capture and data-phase response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'h0;

    case (state_q)
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all finish a data phase this cycle and may take a new address.
        if (state_q == ST_DATA && !write_q) begin
          hrdata = mem[idx_q];
        end
        if (state_q == ST_ERR2) begin
          hresp = 1'b1;
        end
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = bus.HADDR[AW+ADDR_LSB-1:0];
          write_d = bus.HWRITE;
          size_d  = bus.HSIZE;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // State and latched address-phase registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Store commit at the edge that ends the DATA cycle; HWDATA is only looked at here.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) begin
          mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata;

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// tb/tb_ahb_dmem_slave.sv - randomized and directed bench for ahb_dmem_slave against a memory model
module tb_ahb_dmem_slave;

  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb_dmem_slave_if bus0 ();
  ahb_dmem_slave_if bus3 ();

  logic        dsel;
  logic        m_hsel;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic        m_hwrite;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;

  assign bus0.HSEL   = m_hsel && !dsel;
  assign bus0.HADDR  = m_haddr;
  assign bus0.HTRANS = m_htrans;
  assign bus0.HWRITE = m_hwrite;
  assign bus0.HSIZE  = m_hsize;
  assign bus0.HWDATA = m_hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus3.HSEL   = m_hsel && dsel;
  assign bus3.HADDR  = m_haddr;
  assign bus3.HTRANS = m_htrans;
  assign bus3.HWRITE = m_hwrite;
  assign bus3.HSIZE  = m_hsize;
  assign bus3.HWDATA = m_hwdata;
  assign bus3.HREADY = bus3.HREADYOUT;

  wire        o_ready = dsel ? bus3.HREADYOUT : bus0.HREADYOUT;
  wire        o_resp  = dsel ? bus3.HRESP     : bus0.HRESP;
  wire [31:0] o_rdata = dsel ? bus3.HRDATA    : bus0.HRDATA;

  ahb_dmem_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  ahb_dmem_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl [2][DEPTH];

  function automatic int exp_waits(input int d);
    return (d != 0) ? 3 : 0;
  endfunction

  function automatic bit is_illegal(input logic [31:0] a, input logic [2:0] s);
    int unsigned nbytes;
    if (s > 3'd2) return 1'b1;
    nbytes = 1 << s;
    if ((a % nbytes) != 0) return 1'b1;
    if (a >= DEPTH * 4) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_store(input int d, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    int unsigned w;
    int unsigned off;
    w = a / 4;
    off = a % 4;
    for (int k = 0; k < (1 << s); k++) begin
      mdl[d][w][8*(off+k) +: 8] = wd[8*(off+k) +: 8];
    end
  endtask

  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] wd, output int waits, output logic resp_first,
                      output logic resp_last, output logic [31:0] rd, output bit to);
    int cyc;
    @(negedge clk);
    dsel = (d != 0);
    m_hsel = 1'b1;
    m_htrans = 2'b10;
    m_haddr = a;
    m_hwrite = wr;
    m_hsize = s;
    @(negedge clk);
    m_hsel = 1'b0;
    m_htrans = 2'b00;
    waits = 0;
    cyc = 0;
    resp_first = o_resp;
    while (o_ready !== 1'b1 && cyc < 40) begin
      m_hwdata = $urandom;
      waits++;
      cyc++;
      @(negedge clk);
    end
    m_hwdata = wd;
    rd = o_rdata;
    resp_last = o_resp;
    to = (cyc >= 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      dsel = (d != 0);
      #1;
      n_checks++;
      if (o_ready !== 1'b1) $display("FAIL reset_hreadyout dut%0d got %b want 1", d, o_ready);
      else n_pass++;
      n_checks++;
      if (o_resp !== 1'b0) $display("FAIL reset_hresp dut%0d got %b want 0", d, o_resp);
      else n_pass++;
      n_checks++;
      if (o_rdata !== 32'h0) $display("FAIL reset_hrdata dut%0d got %h want 0", d, o_rdata);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_rw();
    int w; logic rf, rl; logic [31:0] rd; bit to;
    xfer(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, w, rf, rl, rd, to);
    model_store(0, 32'h10, 3'b010, 32'hDEADBEEF);
    n_checks++;
    if (to || w !== 0 || rl !== 1'b0) $display("FAIL word_store waits=%0d resp=%b to=%0d want 0/0/0", w, rl, to);
    else n_pass++;
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (to || w !== 0 || rl !== 1'b0) $display("FAIL word_load_resp waits=%0d resp=%b to=%0d want 0/0/0", w, rl, to);
    else n_pass++;
    n_checks++;
    if (rd !== 32'hDEADBEEF) $display("FAIL word_load_data got %h want deadbeef", rd);
    else n_pass++;
  endtask

  task automatic test_byte_half();
    int w; logic rf, rl; logic [31:0] rd; bit to;
    xfer(0, 1'b1, 32'h10, 3'b010, 32'h11223344, w, rf, rl, rd, to);
    model_store(0, 32'h10, 3'b010, 32'h11223344);
    xfer(0, 1'b1, 32'h13, 3'b000, 32'hAA000000, w, rf, rl, rd, to);
    model_store(0, 32'h13, 3'b000, 32'hAA000000);
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (rd !== 32'hAA223344) $display("FAIL byte_merge got %h want aa223344", rd);
    else n_pass++;
    xfer(0, 1'b1, 32'h12, 3'b001, 32'h55660000, w, rf, rl, rd, to);
    model_store(0, 32'h12, 3'b001, 32'h55660000);
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (rd !== 32'h55663344) $display("FAIL half_merge got %h want 55663344", rd);
    else n_pass++;
    xfer(0, 1'b1, 32'h11, 3'b000, 32'h00007700, w, rf, rl, rd, to);
    model_store(0, 32'h11, 3'b000, 32'h00007700);
    xfer(0, 1'b0, 32'h10, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (rd !== mdl[0][4]) $display("FAIL byte_lane1 got %h want %h", rd, mdl[0][4]);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    int w; logic rf, rl; logic [31:0] rd; bit to;
    xfer(1, 1'b1, 32'h100, 3'b010, 32'h13579BDF, w, rf, rl, rd, to);
    model_store(1, 32'h100, 3'b010, 32'h13579BDF);
    n_checks++;
    if (to || w !== 3 || rl !== 1'b0 || rf !== 1'b0) $display("FAIL wait_store waits=%0d resp=%b/%b to=%0d want 3/0/0", w, rf, rl, to);
    else n_pass++;
    xfer(1, 1'b0, 32'h100, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (to || w !== 3 || rl !== 1'b0) $display("FAIL wait_load waits=%0d resp=%b to=%0d want 3/0", w, rl, to);
    else n_pass++;
    n_checks++;
    if (rd !== 32'h13579BDF) $display("FAIL wait_load_data got %h want 13579bdf", rd);
    else n_pass++;
  endtask

  task automatic test_errors();
    int w; logic rf, rl; logic [31:0] rd; bit to;
    logic        e_wr [6];
    logic [31:0] e_a  [6];
    logic [2:0]  e_s  [6];
    int          e_d  [6];
    e_wr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    e_a  = '{32'h2, 32'h0, 32'h1000, 32'h5, 32'h2, 32'h1100};
    e_s  = '{3'b010, 3'b011, 3'b010, 3'b001, 3'b010, 3'b010};
    e_d  = '{0, 0, 0, 0, 0, 1};
    xfer(0, 1'b1, 32'h0, 3'b010, 32'hCAFEF00D, w, rf, rl, rd, to);
    model_store(0, 32'h0, 3'b010, 32'hCAFEF00D);
    xfer(0, 1'b1, 32'h4, 3'b010, 32'h01234567, w, rf, rl, rd, to);
    model_store(0, 32'h4, 3'b010, 32'h01234567);
    xfer(1, 1'b1, 32'h100, 3'b010, 32'h2468ACE0, w, rf, rl, rd, to);
    model_store(1, 32'h100, 3'b010, 32'h2468ACE0);
    for (int i = 0; i < 6; i++) begin
      xfer(e_d[i], e_wr[i], e_a[i], e_s[i], 32'hFFFFFFFF, w, rf, rl, rd, to);
      n_checks++;
      if (to || w !== 1 || rf !== 1'b1 || rl !== 1'b1 || rd !== 32'h0)
        $display("FAIL err_resp%0d waits=%0d resp=%b/%b rd=%h to=%0d want 1/1/1/0", i, w, rf, rl, rd, to);
      else n_pass++;
    end
    xfer(0, 1'b0, 32'h0, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (rd !== mdl[0][0]) $display("FAIL err_mem0 got %h want %h", rd, mdl[0][0]);
    else n_pass++;
    xfer(0, 1'b0, 32'h4, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (rd !== mdl[0][1]) $display("FAIL err_mem1 got %h want %h", rd, mdl[0][1]);
    else n_pass++;
    xfer(1, 1'b0, 32'h100, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (rd !== mdl[1][64]) $display("FAIL err_mem3 got %h want %h", rd, mdl[1][64]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int w; logic rf, rl; logic [31:0] rd; bit to;
    logic [31:0] v;
    v = $urandom;
    @(negedge clk);
    dsel = 1'b0;
    m_hsel = 1'b1; m_htrans = 2'b10; m_haddr = 32'h20; m_hwrite = 1'b1; m_hsize = 3'b010;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_resp !== 1'b0) $display("FAIL b2b_store ready=%b resp=%b want 1/0", o_ready, o_resp);
    else n_pass++;
    m_hwdata = v;
    m_hwrite = 1'b0;
    model_store(0, 32'h20, 3'b010, v);
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== mdl[0][8])
      $display("FAIL b2b_load ready=%b resp=%b rd=%h want 1/0/%h", o_ready, o_resp, o_rdata, mdl[0][8]);
    else n_pass++;
    m_htrans = 2'b01;
    m_hwdata = $urandom;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'h0)
      $display("FAIL b2b_busy ready=%b resp=%b rd=%h want 1/0/0", o_ready, o_resp, o_rdata);
    else n_pass++;
    m_htrans = 2'b00;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'h0)
      $display("FAIL b2b_idle ready=%b resp=%b rd=%h want 1/0/0", o_ready, o_resp, o_rdata);
    else n_pass++;
    m_hsel = 1'b0; m_htrans = 2'b10; m_hwrite = 1'b1; m_haddr = 32'h20;
    @(negedge clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'h0)
      $display("FAIL b2b_unsel ready=%b resp=%b rd=%h want 1/0/0", o_ready, o_resp, o_rdata);
    else n_pass++;
    m_hwdata = ~v;
    m_htrans = 2'b00;
    m_hwrite = 1'b0;
    xfer(0, 1'b0, 32'h20, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (to || w !== 0 || rd !== mdl[0][8]) $display("FAIL b2b_after waits=%0d rd=%h want 0/%h", w, rd, mdl[0][8]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int w; logic rf, rl; logic [31:0] rd; bit to;
    xfer(1, 1'b1, 32'h140, 3'b010, 32'h0BADF00D, w, rf, rl, rd, to);
    model_store(1, 32'h140, 3'b010, 32'h0BADF00D);
    @(negedge clk);
    dsel = 1'b1;
    m_hsel = 1'b1; m_htrans = 2'b10; m_haddr = 32'h140; m_hwrite = 1'b1; m_hsize = 3'b010;
    @(negedge clk);
    m_hsel = 1'b0; m_htrans = 2'b00; m_hwdata = 32'hFFFFFFFF;
    n_checks++;
    if (o_ready !== 1'b0) $display("FAIL rst_in_wait ready=%b want 0", o_ready);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'h0)
      $display("FAIL rst_abort ready=%b resp=%b rd=%h want 1/0/0", o_ready, o_resp, o_rdata);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1, 1'b0, 32'h140, 3'b010, 32'h0, w, rf, rl, rd, to);
    n_checks++;
    if (to || w !== 3 || rd !== mdl[1][80]) $display("FAIL rst_keep waits=%0d rd=%h want 3/%h", w, rd, mdl[1][80]);
    else n_pass++;
  endtask

  task automatic test_random();
    int w; logic rf, rl; logic [31:0] rd; bit to;
    logic [31:0] a, wd;
    logic [2:0]  s;
    logic        wr;
    bit          bad;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        wd = $urandom;
        xfer(d, 1'b1, 32'h200 + 32'(4 * i), 3'b010, wd, w, rf, rl, rd, to);
        model_store(d, 32'h200 + 32'(4 * i), 3'b010, wd);
      end
      for (int i = 0; i < 60; i++) begin
        a  = 32'h200 + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 9) == 0) a = a + 32'h1000;
        s  = 3'($urandom_range(0, 3));
        if (s == 3'd3 && $urandom_range(0, 1) == 0) s = 3'($urandom_range(3, 7));
        else if (s == 3'd3) s = 3'd2;
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        bad = is_illegal(a, s);
        xfer(d, wr, a, s, wd, w, rf, rl, rd, to);
        if (bad) begin
          n_checks++;
          if (to || w !== 1 || rf !== 1'b1 || rl !== 1'b1 || rd !== 32'h0)
            $display("FAIL rnd_err dut%0d a=%h s=%0d waits=%0d resp=%b/%b rd=%h", d, a, s, w, rf, rl, rd);
          else n_pass++;
        end else begin
          n_checks++;
          if (to || w !== exp_waits(d) || rl !== 1'b0)
            $display("FAIL rnd_okay dut%0d a=%h s=%0d waits=%0d resp=%b want %0d/0", d, a, s, w, rl, exp_waits(d));
          else n_pass++;
          if (wr) begin
            model_store(d, a, s, wd);
            n_checks++;
            if (rd !== 32'h0) $display("FAIL rnd_wr_rdata dut%0d got %h want 0", d, rd);
            else n_pass++;
          end else begin
            n_checks++;
            if (rd !== mdl[d][a / 4]) $display("FAIL rnd_load dut%0d a=%h got %h want %h", d, a, rd, mdl[d][a / 4]);
            else n_pass++;
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        xfer(d, 1'b0, 32'h200 + 32'(4 * i), 3'b010, 32'h0, w, rf, rl, rd, to);
        n_checks++;
        if (rd !== mdl[d][128 + i]) $display("FAIL rnd_sweep dut%0d w%0d got %h want %h", d, i, rd, mdl[d][128 + i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    dsel = 1'b0;
    m_hsel = 1'b0;
    m_haddr = 32'h0;
    m_htrans = 2'b00;
    m_hwrite = 1'b0;
    m_hsize = 3'b000;
    m_hwdata = 32'h0;
    test_reset();
    test_word_rw();
    test_byte_half();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
